ram_arb_ctrl: RTL and testbench

Two-port round-robin arbiter and sequencer for the 4-entry x 5-bit synchronous RAM. Two requesters (port 0, port 1) issue single-word read or write requests with a req/ack handshake. The block grants one request at a time, drives the RAM's active-low enable and write/read select, and returns read data with a one-cycle valid pulse to the granted port. It sits directly in front of the RAM; no other master drives the RAM.

---
 rtl/ram_arb_ctrl.sv | 122 ++++++++++++
 tb/tb_ram_arb_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb_ctrl.sv
// Round-robin arbiter/sequencer placing two single-word request ports in front of
// a small synchronous RAM with active-low enable and registered read data.
module ram_arb_ctrl #(
   parameter int DW = 5,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          busy,
   output logic          ram_en,
   output logic          ram_wr,
   output logic [AW-1:0] ram_add,
   output logic [DW-1:0] ram_w_data,
   input  logic [DW-1:0] ram_r_data
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RDATA  = 2'd2;

   logic [1:0] state;
   logic       last_port;  // port granted most recently; reset to 1 so port 0 wins first tie
   logic       gnt_port;
   logic       gnt_rd;
   logic       pick0;
   logic       pick1;

   always_comb begin
      pick0 = req0 & (~req1 | last_port);
      pick1 = req1 & ~pick0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_port  <= 1'b1;
         gnt_port   <= 1'b0;
         gnt_rd     <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         busy       <= 1'b0;
         ram_en     <= 1'b1;
         ram_wr     <= 1'b1;
         ram_add    <= '0;
         ram_w_data <= '0;
      end else begin
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         case (state)
            IDLE: begin
               if (pick0 || pick1) begin
                  state     <= ACCESS;
                  busy      <= 1'b1;
                  ram_en    <= 1'b0;
                  last_port <= pick1;
                  gnt_port  <= pick1;
                  if (pick1) begin
                     gnt_rd     <= ~we1;
                     ram_wr     <= ~we1;
                     ram_add    <= addr1;
                     ram_w_data <= we1 ? wdata1 : '0;
                     ack1       <= 1'b1;
                  end else begin
                     gnt_rd     <= ~we0;
                     ram_wr     <= ~we0;
                     ram_add    <= addr0;
                     ram_w_data <= we0 ? wdata0 : '0;
                     ack0       <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // The RAM performs the access on the edge that leaves this state.
               ram_en <= 1'b1;
               ram_wr <= 1'b1;
               if (gnt_rd) begin
                  state <= RDATA;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RDATA: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (gnt_port) begin
                  rdata1  <= ram_r_data;
                  rvalid1 <= 1'b1;
               end else begin
                  rdata0  <= ram_r_data;
                  rvalid0 <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Directed bench for ram_arb_ctrl with a behavioural 4x5 synchronous RAM attached.
module tb_ram_arb_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [1:0] addr0 = '0, addr1 = '0;
   logic [4:0] wdata0 = '0, wdata1 = '0;
   logic       ack0, ack1, rvalid0, rvalid1, busy, ram_en, ram_wr;
   logic [4:0] rdata0, rdata1, ram_w_data;
   logic [1:0] ram_add;
   logic [4:0] ram_r_data = '0;
   logic [4:0] mem [4];

   int checks = 0;
   int errors = 0;

   ram_arb_ctrl #(.DW(5), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .ram_en(ram_en), .ram_wr(ram_wr), .ram_add(ram_add),
      .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_en) begin
         if (!ram_wr) mem[ram_add] <= ram_w_data;
         else         ram_r_data   <= mem[ram_add];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic we, input logic [1:0] a, input logic [4:0] d);
      if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
   endtask

   task automatic do_write(input int p, input logic [1:0] a, input logic [4:0] d);
      set_req(p, 1'b1, a, d);
      tick();
      chk("wr_ack", (p == 0) ? ack0 : ack1, 1);
      chk("wr_ram_en", ram_en, 0);
      chk("wr_ram_wr", ram_wr, 0);
      chk("wr_ram_add", ram_add, a);
      chk("wr_ram_w_data", ram_w_data, d);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("wr_ack_drop", {ack0, ack1}, 0);
      chk("wr_ram_en_high", ram_en, 1);
      chk("wr_busy_low", busy, 0);
   endtask

   task automatic do_read(input int p, input logic [1:0] a, input logic [4:0] exp);
      set_req(p, 1'b0, a, 5'h1F);
      tick();
      chk("rd_ack", (p == 0) ? ack0 : ack1, 1);
      chk("rd_ram_en", ram_en, 0);
      chk("rd_ram_wr", ram_wr, 1);
      chk("rd_ram_w_data", ram_w_data, 0);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("rd_busy_access", busy, 1);
      chk("rd_no_early_rvalid", {rvalid0, rvalid1}, 0);
      tick();
      chk("rd_rvalid", (p == 0) ? {rvalid0, rvalid1} : {rvalid1, rvalid0}, 2'b10);
      chk("rd_rdata", (p == 0) ? rdata0 : rdata1, exp);
      chk("rd_busy_done", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_ram_en", ram_en, 1);
      chk("rst_ram_wr", ram_wr, 1);
      chk("rst_busy", busy, 0);
      chk("rst_acks", {ack0, ack1, rvalid0, rvalid1}, 0);
      chk("rst_rdata", {rdata0, rdata1}, 0);
      chk("rst_ram_bus", {ram_add, ram_w_data}, 0);
      rst = 1'b0;
      tick();
      chk("idle_no_req", {busy, ram_en}, 2'b01);

      // Single write then read on port 0
      do_write(0, 2'd2, 5'h15);
      do_read(0, 2'd2, 5'h15);
      tick();
      chk("rvalid0_one_cycle", rvalid0, 0);
      chk("rdata0_held", rdata0, 5'h15);

      // Simultaneous writes right after reset: port 0 first
      #3 rst = 1'b1;
      #2 rst = 1'b0;
      tick();
      set_req(0, 1'b1, 2'd1, 5'h0A);
      set_req(1, 1'b1, 2'd3, 5'h1F);
      tick();
      chk("sim_ack0_first", {ack0, ack1}, 2'b10);
      chk("sim_add0", ram_add, 1);
      req0 = 1'b0;
      tick();
      chk("sim_gap", {ack0, ack1, ram_en, busy}, 4'b0010);
      tick();
      chk("sim_ack1_second", {ack0, ack1}, 2'b01);
      chk("sim_w1", {ram_add, ram_w_data}, {2'd3, 5'h1F});
      req1 = 1'b0;
      tick();
      do_read(0, 2'd1, 5'h0A);
      do_read(1, 2'd3, 5'h1F);

      // Round robin with both ports holding read requests
      set_req(0, 1'b0, 2'd1, 5'h00);
      set_req(1, 1'b0, 2'd3, 5'h00);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_ack", {ack0, ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
         tick();
         tick();
         chk("rr_rvalid", {rvalid0, rvalid1}, (i % 2 == 0) ? 2'b10 : 2'b01);
         chk("rr_rdata", (i % 2 == 0) ? rdata0 : rdata1, (i % 2 == 0) ? 5'h0A : 5'h1F);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("rr_idle", {busy, ack0, ack1}, 0);

      // Reset during RDATA of a port 1 read
      do_write(0, 2'd3, 5'h07);
      set_req(1, 1'b0, 2'd3, 5'h00);
      tick();
      chk("mr_ack1", ack1, 1);
      req1 = 1'b0;
      tick();
      chk("mr_in_rdata_busy", busy, 1);
      chk("mr_ram_r_data", ram_r_data, 5'h07);
      #3 rst = 1'b1;
      #1;
      chk("mr_async_busy", busy, 0);
      chk("mr_async_ram_en", ram_en, 1);
      chk("mr_rdata1_cleared", rdata1, 0);
      #2 rst = 1'b0;
      tick();
      chk("mr_no_rvalid", {rvalid0, rvalid1, busy}, 0);
      chk("mr_rdata1_zero", rdata1, 0);
      set_req(0, 1'b0, 2'd3, 5'h00);
      set_req(1, 1'b0, 2'd2, 5'h00);
      tick();
      chk("mr_port0_first", {ack0, ack1}, 2'b10);
      req0 = 1'b0;
      tick();
      tick();
      chk("mr_rd0", {rvalid0, rdata0}, {1'b1, 5'h07});
      tick();
      chk("mr_port1_next", {ack0, ack1}, 2'b01);
      req1 = 1'b0;
      tick();
      tick();
      chk("mr_rd1", {rvalid1, rdata1}, {1'b1, 5'h15});

      // Request withdrawn before it can be sampled in IDLE
      set_req(0, 1'b1, 2'd0, 5'h11);
      tick();
      chk("wd_ack0", ack0, 1);
      req0 = 1'b0;
      set_req(1, 1'b1, 2'd0, 5'h1E);
      tick();
      req1 = 1'b0;
      tick();
      chk("wd_no_ack1", {ack0, ack1}, 0);
      chk("wd_no_access", {ram_en, busy}, 2'b10);
      tick();
      chk("wd_still_idle", {ram_en, busy}, 2'b10);
      do_read(0, 2'd0, 5'h11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
